// File: rtl/fetch_pkg.sv
// Shared types for the fetch unit and its sequencer.
package fetch_pkg;
    localparam int INS_SIZE = 32;
    localparam int PC_NUM   = 16;
    localparam int PC_W     = $clog2(PC_NUM);

    typedef logic [INS_SIZE-1:0] instruction_t;
    typedef logic [PC_W-1:0]     pc_t;

    localparam pc_t PC_LAST = pc_t'(PC_NUM - 1);

    typedef enum logic {
        fetch_keep = 1'b0,
        fetch_next = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        ctrl_idle  = 2'd0,
        ctrl_run   = 2'd1,
        ctrl_step  = 2'd2,
        ctrl_drain = 2'd3
    } fetch_ctrl_state_t;

    typedef struct packed {
        instruction_t inst;
        pc_t          pc;
    } buf_entry_t;

    // Sequencer transition; drained means the buffer is empty after this cycle.
    function automatic fetch_ctrl_state_t ctrl_next(
        input fetch_ctrl_state_t s,
        input logic              halt,
        input logic              run,
        input logic              step,
        input logic              cap,
        input logic              drained
    );
        fetch_ctrl_state_t n;
        n = s;
        case (s)
            ctrl_idle: begin
                if (halt)      n = ctrl_idle;
                else if (run)  n = ctrl_run;
                else if (step) n = ctrl_step;
            end
            ctrl_run:   if (halt) n = ctrl_drain;
            ctrl_step:  if (halt || cap) n = ctrl_drain;
            ctrl_drain: if (drained) n = ctrl_idle;
            default:    n = ctrl_idle;
        endcase
        return n;
    endfunction
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry register FIFO between fetch capture and decode.
// Slot 0 is always the head, so the head holds its last value once empty.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  buf_entry_t    din,
    input  logic          pop,
    output buf_entry_t    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    buf_entry_t ent0;
    buf_entry_t ent1;
    logic       do_pop;
    logic       do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = ent0;

    // Shift-style storage and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= '0;
        end else begin
            if (count == '0) begin
                if (do_push) ent0 <= din;
            end else if (count == CNT_ONE) begin
                if (do_pop) begin
                    if (do_push) ent0 <= din;
                end else if (do_push) begin
                    ent1 <= din;
                end
            end else begin
                if (do_pop) begin
                    ent0 <= ent1;
                    if (do_push) ent1 <= din;
                end
            end
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: advances the fetch PC only on a same-cycle capture and
// hands captured instructions to decode through a two-entry buffer.
//
//   state      | meaning
//   ctrl_idle  | no fetching; waits for run or step
//   ctrl_run   | capture every cycle the buffer has room
//   ctrl_step  | capture exactly one instruction
//   ctrl_drain | no capture; wait for buffer to empty
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic               step_i,
    input  logic               halt_i,
    input  instruction_t       fetch_inst_i,
    input  pc_t                fetch_id_i,
    output fetch_state_t       fetch_state_o,
    output logic               dec_valid_o,
    input  logic               dec_ready_i,
    output instruction_t       dec_inst_o,
    output pc_t                dec_pc_o,
    output logic               busy_o,
    output logic               wrap_o,
    output logic [CNT_W-1:0]   inst_count_o
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_ctrl_state_t state;
    fetch_ctrl_state_t state_nxt;
    buf_entry_t        cap_entry;
    buf_entry_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              fetch_en;
    logic              pop;
    logic              cap;
    logic              drained;

    // Halt blocks capture in the same cycle it is seen in RUN or STEP.
    assign fetch_en  = ((state == ctrl_run) || (state == ctrl_step)) && !halt_i;
    assign pop       = dec_valid_o & dec_ready_i;
    assign cap       = fetch_en & (~fifo_full | pop);
    assign cnt_nxt   = cnt + CW'(cap) - CW'(pop);
    assign drained   = (cnt == '0) || ((cnt == CW'(1)) && pop);
    assign state_nxt = ctrl_next(state, halt_i, run_i, step_i, cap, drained);

    assign fetch_state_o = (cap && !rst) ? fetch_next : fetch_keep;

    assign cap_entry.inst = fetch_inst_i;
    assign cap_entry.pc   = fetch_id_i;

    assign dec_valid_o = ~fifo_empty;
    assign dec_inst_o  = head.inst;
    assign dec_pc_o    = head.pc;

    fetch_skid_fifo #(.DEPTH(DEPTH), .CW(CW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (cap),
        .din   (cap_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (cnt)
    );

    // Sequencer state plus registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ctrl_idle;
            busy_o       <= 1'b0;
            wrap_o       <= 1'b0;
            inst_count_o <= '0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != ctrl_idle) || (cnt_nxt != '0);
            wrap_o <= cap && (fetch_id_i == PC_LAST);
            if (cap) inst_count_o <= inst_count_o + 1'b1;
        end
    end
endmodule
